// File: rtl/rcvbuf.sv
// rcvbuf: UART 8N1 receiver with a one-deep holding register and ready/read handshake
module rcvbuf #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       read,
  output logic       ready,
  output logic [7:0] data_out,
  output logic       overrun,
  output logic       framing_err
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic done, done_n, bad, bad_n;
  logic s1, rx;
  // two-flop synchronizer, preset to the idle-high line level
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1, rx} <= 2'b11;
    else {s1, rx} <= {serial_in, s1};
  // frame state, bit timer, shift register and one-cycle delivery/error pulses
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      done <= 1'b0;
      bad <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      done <= done_n;
      bad <= bad_n;
    end
  // next-state: start is re-checked at half bit, then every sample lands mid-bit
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    done_n = 1'b0;
    bad_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx) state_n = START;
      end
      START:
        if (cnt == HALF) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = rx ? IDLE : DATA;
        end
      DATA:
        if (cnt == LAST) begin
          cnt_n = '0;
          shift_n = {rx, shift[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      default:
        if (cnt == LAST) begin
          cnt_n = '0;
          state_n = IDLE;
          done_n = rx;
          bad_n = !rx;
        end
    endcase
  end
  // holding register: delivery wins over read, overrun only when an unread byte is lost
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ready <= 1'b0;
      data_out <= 8'h00;
      overrun <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (done) begin
        data_out <= shift;
        ready <= 1'b1;
        if (ready && !read) overrun <= 1'b1;
      end else if (ready && read) begin
        ready <= 1'b0;
        overrun <= 1'b0;
      end
      if (bad) framing_err <= 1'b1;
      else if (ready && read) framing_err <= 1'b0;
    end
endmodule

// File: tb/tb_rcvbuf.sv
// tb_rcvbuf: directed frames for rcvbuf with a scoreboard-driven delivery monitor
module tb_rcvbuf;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic serial_in = 1'b1;
  logic read = 1'b0;
  logic ready, overrun, framing_err;
  logic [7:0] data_out;
  int vectors = 0;
  int miscompares = 0;
  int lat = 0;
  typedef struct packed {logic [7:0] d; logic ov; logic fe;} exp_t;
  exp_t sb[$];
  logic pr = 1'b0;
  logic [7:0] pd = 8'h00;

  rcvbuf #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .read(read),
    .ready(ready), .data_out(data_out), .overrun(overrun), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = stop;
    repeat (CPB) @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic pulse_read;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
  endtask

  // monitor: each new byte presented in the holding register is checked against the queue
  always @(negedge clk) begin
    exp_t e;
    if (reset && ready && (!pr || data_out !== pd)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_delivery: got %0h expected none", data_out);
      end else begin
        e = sb.pop_front();
        chk("rx_data", data_out, e.d);
        chk("rx_overrun", overrun, e.ov);
        chk("rx_framing", framing_err, e.fe);
      end
    end
    pr = ready;
    pd = data_out;
  end

  initial begin
    idle(3);
    chk("reset_ready", ready, 0);
    chk("reset_data", data_out, 8'h00);
    chk("reset_overrun", overrun, 0);
    chk("reset_framing", framing_err, 0);
    reset = 1'b1;
    idle(5);
    // basic byte and latency
    sb.push_back('{8'h55, 1'b0, 1'b0});
    fork
      send(8'h55, 1'b1);
      while (!ready && lat < 400) begin
        @(posedge clk);
        #1;
        lat++;
      end
    join
    vectors++;
    if (lat < 150 || lat > 165) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles expected about 156", lat);
    end
    idle(4);
    pulse_read;
    chk("read_ready", ready, 0);
    chk("read_data_held", data_out, 8'h55);
    // back to back without read: overrun
    sb.push_back('{8'hA3, 1'b0, 1'b0});
    sb.push_back('{8'h0F, 1'b1, 1'b0});
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b1);
    idle(8);
    chk("ovr_ready", ready, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_data", data_out, 8'h0F);
    pulse_read;
    chk("ovr_clr_ready", ready, 0);
    chk("ovr_clr_flag", overrun, 0);
    // bad stop bit then a good frame
    send(8'h3C, 1'b0);
    idle(30);
    chk("fe_ready", ready, 0);
    chk("fe_data", data_out, 8'h0F);
    chk("fe_flag", framing_err, 1);
    sb.push_back('{8'h81, 1'b0, 1'b1});
    send(8'h81, 1'b1);
    idle(8);
    chk("fe_next_ready", ready, 1);
    chk("fe_next_data", data_out, 8'h81);
    pulse_read;
    chk("fe_clr", framing_err, 0);
    // start-bit glitch
    serial_in = 1'b0;
    idle(5);
    serial_in = 1'b1;
    idle(40);
    chk("glitch_ready", ready, 0);
    chk("glitch_ovr", overrun, 0);
    chk("glitch_fe", framing_err, 0);
    sb.push_back('{8'hFF, 1'b0, 1'b0});
    send(8'hFF, 1'b1);
    idle(8);
    pulse_read;
    // read coinciding with a new delivery
    sb.push_back('{8'h12, 1'b0, 1'b0});
    send(8'h12, 1'b1);
    idle(8);
    sb.push_back('{8'h77, 1'b0, 1'b0});
    fork
      send(8'h77, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
      end
    join
    idle(4);
    chk("coinc_ready", ready, 1);
    chk("coinc_data", data_out, 8'h77);
    chk("coinc_ovr", overrun, 0);
    pulse_read;
    // reset in the middle of a frame
    fork
      send(8'hC6, 1'b1);
      begin
        repeat (88) @(negedge clk);
        reset = 1'b0;
      end
    join
    idle(4);
    reset = 1'b1;
    idle(4);
    chk("midrst_ready", ready, 0);
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_ovr", overrun, 0);
    chk("midrst_fe", framing_err, 0);
    sb.push_back('{8'h5A, 1'b0, 1'b0});
    send(8'h5A, 1'b1);
    idle(8);
    chk("final_ready", ready, 1);
    chk("final_data", data_out, 8'h5A);
    chk("final_ovr", overrun, 0);
    chk("final_fe", framing_err, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
